dm_access_arbiter: RTL and testbench
====================================

# dm_access_arbiter

Two-port controller that shares the single data-memory bank between the CPU M-stage (port 0) and the bridge/debug master (port 1). It arbitrates round-robin and generates byte enables and replicated store data for word/half/byte accesses. It sequences each access against a variable-latency memory using a `mem_req`/`mem_ready` handshake. Load data comes back already aligned and sign/zero-extended, with a registered `done` pulse per access.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req0`/`req1`, in, 1: access request; held high until the matching `gnt`.
- `we0`/`we1`, in, 1: 1 = store, 0 = load.
- `addr0`/`addr1`, in, `ADDR_W`: byte address.
- `type0`/`type1`, in, 3: access type code (package constants).
- `wdata0`/`wdata1`, in, 32: store data, right-aligned.
- `gnt0`/`gnt1`, out, 1: combinational; high in the IDLE cycle in which the request is latched.
- `done0`/`done1`, out, 1: one-cycle registered completion pulse.
- `rdata`, out, 32: extracted load data; valid while a `done` is high, otherwise 0.
- `err`, out, 1: misaligned access; valid with `done`.
- `mem_req`, out, 1: memory access active.
- `mem_we`, out, 1: memory write.
- `mem_addr`, out, `ADDR_W`-2: word address (`addr[ADDR_W-1:2]`).
- `mem_be`, out, 4: byte enables.
- `mem_wdata`, out, 32: replicated store data.
- `mem_ready`, in, 1: memory completes the access this cycle.
- `mem_rdata`, in, 32: raw word; valid when `mem_ready` is high.

## Operation
- FSM with three states: IDLE, ISSUE, DONE.
- **IDLE.** Pick a winner among the active requests.
  - If both ports request, grant the port that is not `last_grant`.
  - Assert the winner's `gnt`. Latch its `we`/`addr`/`type`/`wdata` and its port id, and update `last_grant`.
  - Go to ISSUE. With no request, stay in IDLE.
- **ISSUE.** Drive `mem_req=1` and the latched fields.
  - `mem_ready=0`: hold every output stable.
  - `mem_ready=1`: register the extracted `mem_rdata`, then go to DONE.
- **DONE.**
  - Pulse `done` for the latched port and drive `rdata`/`err`.
  - `mem_req=0`. Go to IDLE.
- **Byte enables.**
  - Word: `1111`.
  - Half: `0011 << addr[1:0]`.
  - Byte: `0001 << addr[1:0]`.
  - Loads drive the same `mem_be` with `mem_we=0`.
- **Store data.** Byte writes `{4{wdata[7:0]}}`; half writes `{2{wdata[15:0]}}`; word writes `wdata` unchanged.
- **Load extraction.** Select the byte or halfword by `addr[1:0]`, then sign-extend (HALF, BYTE) or zero-extend (HALFU, BYTEU). WORD passes through.
- Store completions give `rdata=0`.
- Undefined type codes behave as WORD.

## Timing
- Reset values:
  - Every output is 0.
  - State is IDLE.
  - `last_grant=1`, so port 0 wins the first tie.
- Reset is asynchronous. Asserting `reset_n` mid-access drops `mem_req` immediately, and the in-flight access is discarded without a `done`.
- Latency with request at cycle 0 and zero wait states:
  - Cycle 0: `gnt`.
  - Cycle 1: `mem_req` with `mem_ready`.
  - Cycle 2: `done`.
- Each wait cycle adds one cycle. Minimum occupancy is 3 cycles per access.
- A request that arrives during ISSUE or DONE waits for IDLE. A requester must keep `req` high until `gnt`.
- `mem_ready` is ignored outside ISSUE.

## Configuration
- **`DM_ARB_ALIGN_CHECK_EN` defined:**
  - Misaligned WORD (`addr[1:0]!=0`) and misaligned HALF/HALFU (`addr[0]!=0`) skip ISSUE: IDLE goes straight to DONE.
  - DONE then has `err=1`, `rdata=0`, and no memory cycle. This feeds AdEL/AdES.
- **Undefined:** the check is absent.
  - `err` is tied to 0.
  - The unused low address bits are forced to 0: WORD uses `addr[1:0]=00`, HALF uses `addr[0]=0`.

## Structure
- Shared package `dm_pkg`:
  - Type codes: `DM_WORD=0`, `DM_HALF=1`, `DM_BYTE=2`, `DM_HALFU=3`, `DM_BYTEU=4`.
  - FSM state encoding.
- Sub-module `dm_load_extract`: combinational. Inputs are `addr[1:0]`, type and raw word; output is the extended data. It is instantiated once, before the `rdata` register.
- Byte-enable and store-replication logic stays inline.

## Test plan
- **Port-0 word load.** `req0`, `type0=WORD`, `addr0=0x100`, `mem_ready` in the first ISSUE cycle, `mem_rdata=0xDEADBEEF` → `gnt0` at cycle 0, `mem_addr=0x40`, `mem_be=1111`, `done0` at cycle 2 with `rdata=0xDEADBEEF`.
- **Byte store with 2 wait states.** `req1`, `we1=1`, `type1=BYTE`, `addr1=0x103`, `wdata1=0x000000A5` → `mem_be=1000`, `mem_wdata=0xA5A5A5A5`, `mem_req` high for 3 cycles, `done1` at cycle 4.
- **Signed/unsigned halfword loads.** `addr=0x102`, `mem_rdata=0x8001FFFF` → `type=HALF` gives `rdata=0xFFFF8001`; `type=HALFU` gives `0x00008001`.
- **Tie arbitration.** `req0` and `req1` held high together from reset → grants in order 0, 1, 0, 1, each exactly 3 cycles apart with zero wait states.
- **Misaligned word load** (`DM_ARB_ALIGN_CHECK_EN` defined). `type=WORD`, `addr=0x102` → `mem_req` stays 0, `done` at cycle 1 with `err=1`, `rdata=0`.
- **Mid-access reset.** Drop `reset_n` during ISSUE while `mem_ready=0` → `mem_req` falls immediately, no `done`. After release, a tie is granted to port 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access path: access type codes and arbiter FSM states.
package dm_pkg;

    localparam logic [2:0] DM_WORD  = 3'd0;
    localparam logic [2:0] DM_HALF  = 3'd1;
    localparam logic [2:0] DM_BYTE  = 3'd2;
    localparam logic [2:0] DM_HALFU = 3'd3;
    localparam logic [2:0] DM_BYTEU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } dm_state_t;

endpackage

// File: rtl/dm_load_extract.sv
// Load-data alignment: picks the addressed byte/halfword from a raw memory word and extends it.
module dm_load_extract
    import dm_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dtype,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (addr_lo)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase
        half_sel = addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    always_comb begin
        data = raw;
        case (dtype)
            DM_HALF:  data = {{16{half_sel[15]}}, half_sel};
            DM_HALFU: data = {16'h0000, half_sel};
            DM_BYTE:  data = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTEU: data = {24'h000000, byte_sel};
            default:  data = raw;
        endcase
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Round-robin two-port arbiter sharing one data-memory bank with a req/ready handshake.
// Optional misalignment trapping is enabled by defining DM_ARB_ALIGN_CHECK_EN.
module dm_access_arbiter
    import dm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [2:0]        type0,
    input  logic [31:0]       wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [2:0]        type1,
    input  logic [31:0]       wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata
);

    dm_state_t         state_q, state_d;
    logic              last_grant_q;
    logic              port_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              any_req;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [2:0]        sel_type;
    logic [31:0]       sel_wdata;
    logic [ADDR_W-1:0] addr_fixed;
    logic              misaligned;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       ext_data;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        any_req   = req0 | req1;
        pick      = (req0 && req1) ? ~last_grant_q : req1;
        sel_we    = pick ? we1    : we0;
        sel_addr  = pick ? addr1  : addr0;
        sel_type  = pick ? type1  : type0;
        sel_wdata = pick ? wdata1 : wdata0;
    end

`ifdef DM_ARB_ALIGN_CHECK_EN
    always_comb begin
        addr_fixed = sel_addr;
        case (sel_type)
            DM_HALF, DM_HALFU: misaligned = sel_addr[0];
            DM_BYTE, DM_BYTEU: misaligned = 1'b0;
            default:           misaligned = (sel_addr[1:0] != 2'b00);
        endcase
    end
`else
    // Without trapping, address bits below the access size are simply ignored.
    always_comb begin
        misaligned = 1'b0;
        case (sel_type)
            DM_HALF, DM_HALFU: addr_fixed = {sel_addr[ADDR_W-1:1], 1'b0};
            DM_BYTE, DM_BYTEU: addr_fixed = sel_addr;
            default:           addr_fixed = {sel_addr[ADDR_W-1:2], 2'b00};
        endcase
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (any_req) state_d = misaligned ? ST_DONE : ST_ISSUE;
            ST_ISSUE: if (mem_ready) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            type_q       <= DM_WORD;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && any_req) begin
                last_grant_q <= pick;
                port_q       <= pick;
                we_q         <= sel_we;
                addr_q       <= addr_fixed;
                type_q       <= sel_type;
                wdata_q      <= sel_wdata;
                rdata_q      <= '0;
                err_q        <= misaligned;
            end
            if (state_q == ST_ISSUE && mem_ready) begin
                rdata_q <= we_q ? '0 : ext_data;
            end
        end
    end

    dm_load_extract u_extract (
        .addr_lo (addr_q[1:0]),
        .dtype   (type_q),
        .raw     (mem_rdata),
        .data    (ext_data)
    );

    always_comb begin
        case (type_q)
            DM_HALF, DM_HALFU: begin
                be        = 4'b0011 << addr_q[1:0];
                wdata_rep = {2{wdata_q[15:0]}};
            end
            DM_BYTE, DM_BYTEU: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    always_comb begin
        gnt0      = (state_q == ST_IDLE) && any_req && !pick;
        gnt1      = (state_q == ST_IDLE) && any_req && pick;
        mem_req   = (state_q == ST_ISSUE);
        mem_we    = mem_req && we_q;
        mem_addr  = mem_req ? addr_q[ADDR_W-1:2] : '0;
        mem_be    = mem_req ? be : '0;
        mem_wdata = mem_req ? wdata_rep : '0;
        done0     = (state_q == ST_DONE) && !port_q;
        done1     = (state_q == ST_DONE) && port_q;
        rdata     = (state_q == ST_DONE) ? rdata_q : '0;
`ifdef DM_ARB_ALIGN_CHECK_EN
        err       = (state_q == ST_DONE) && err_q;
`else
        err       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Directed self-checking bench for dm_access_arbiter (covers DM_ARB_ALIGN_CHECK_EN when defined).
module tb_dm_access_arbiter;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [2:0]  type0, type1;
    logic        gnt0, gnt1, done0, done1, err;
    logic [31:0] rdata;
    logic        mem_req, mem_we, mem_ready;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_access_arbiter #(.ADDR_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .type0     (type0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .type1     (type1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait-state load on port 0; ebe/erd are the hand-computed byte enables and result.
    task automatic load0(input string tag, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] raw, input logic [29:0] eaddr,
                         input logic [3:0] ebe, input logic [31:0] erd);
        req0 = 1'b1; we0 = 1'b0; type0 = t; addr0 = a;
        #1;
        check({tag, "_gnt0"}, 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0; mem_ready = 1'b1; mem_rdata = raw;
        #1;
        check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(eaddr));
        check({tag, "_mem_be"}, 32'(mem_be), 32'(ebe));
        step();
        mem_ready = 1'b0;
        #1;
        check({tag, "_done0"}, 32'(done0), 32'd1);
        check({tag, "_rdata"}, rdata, erd);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mem_req_off"}, 32'(mem_req), 32'd0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; type0 = DM_WORD; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; type1 = DM_WORD; wdata1 = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        step();
        step();
        check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check("rst_done", {30'd0, done1, done0}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_be", 32'(mem_be), 32'd0);
        reset_n = 1'b1;
        step();

        // Port-0 word load, zero wait states.
        load0("wload", DM_WORD, 32'h100, 32'hDEADBEEF, 30'h40, 4'b1111, 32'hDEADBEEF);
        check("wload_idle_rdata", rdata, 32'd0);

        // Port-1 byte store with two wait states.
        req1 = 1'b1; we1 = 1'b1; type1 = DM_BYTE; addr1 = 32'h103; wdata1 = 32'h000000A5;
        #1;
        check("bst_gnt1", 32'(gnt1), 32'd1);
        check("bst_gnt0", 32'(gnt0), 32'd0);
        step();
        req1 = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h11223344;
        #1;
        check("bst_mem_req_c1", 32'(mem_req), 32'd1);
        check("bst_mem_we", 32'(mem_we), 32'd1);
        check("bst_mem_be", 32'(mem_be), 32'h8);
        check("bst_mem_wdata", mem_wdata, 32'hA5A5A5A5);
        check("bst_mem_addr", 32'(mem_addr), 32'h40);
        step();
        check("bst_mem_req_c2", 32'(mem_req), 32'd1);
        check("bst_done1_c2", 32'(done1), 32'd0);
        check("bst_mem_wdata_c2", mem_wdata, 32'hA5A5A5A5);
        step();
        mem_ready = 1'b1;
        #1;
        check("bst_mem_req_c3", 32'(mem_req), 32'd1);
        step();
        mem_ready = 1'b0;
        check("bst_done1_c4", 32'(done1), 32'd1);
        check("bst_done0_c4", 32'(done0), 32'd0);
        check("bst_rdata", rdata, 32'd0);
        check("bst_mem_req_c4", 32'(mem_req), 32'd0);
        step();
        check("bst_done1_c5", 32'(done1), 32'd0);

        // Extraction cases.
        load0("half",  DM_HALF,  32'h102, 32'h8001FFFF, 30'h40, 4'b1100, 32'hFFFF8001);
        load0("halfu", DM_HALFU, 32'h102, 32'h8001FFFF, 30'h40, 4'b1100, 32'h00008001);
        load0("byte1", DM_BYTE,  32'h101, 32'h12348056, 30'h40, 4'b0010, 32'hFFFFFF80);
        load0("byteu", DM_BYTEU, 32'h101, 32'h12348056, 30'h40, 4'b0010, 32'h00000080);
        load0("byte3", DM_BYTE,  32'h107, 32'h7F000000, 30'h41, 4'b1000, 32'h0000007F);
        load0("undef", 3'd7,     32'h200, 32'hCAFEF00D, 30'h80, 4'b1111, 32'hCAFEF00D);

`ifdef DM_ARB_ALIGN_CHECK_EN
        req0 = 1'b1; we0 = 1'b0; type0 = DM_WORD; addr0 = 32'h102;
        #1;
        check("mis_w_gnt0", 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0;
        check("mis_w_mem_req", 32'(mem_req), 32'd0);
        check("mis_w_done0", 32'(done0), 32'd1);
        check("mis_w_err", 32'(err), 32'd1);
        check("mis_w_rdata", rdata, 32'd0);
        step();
        check("mis_w_done_off", 32'(done0), 32'd0);
        check("mis_w_err_off", 32'(err), 32'd0);
        req0 = 1'b1; type0 = DM_HALF; addr0 = 32'h101;
        #1;
        step();
        req0 = 1'b0;
        check("mis_h_mem_req", 32'(mem_req), 32'd0);
        check("mis_h_err", 32'(err), 32'd1);
        step();
`else
        load0("unal_w", DM_WORD, 32'h102, 32'h01234567, 30'h40, 4'b1111, 32'h01234567);
        load0("unal_h", DM_HALF, 32'h103, 32'h8001FFFF, 30'h40, 4'b1100, 32'hFFFF8001);
`endif

        // Mid-access reset: in-flight access discarded.
        req1 = 1'b1; we1 = 1'b0; type1 = DM_WORD; addr1 = 32'h200;
        #1;
        check("mrst_gnt1", 32'(gnt1), 32'd1);
        step();
        req1 = 1'b0; mem_ready = 1'b0;
        #1;
        check("mrst_mem_req_before", 32'(mem_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_mem_req_async", 32'(mem_req), 32'd0);
        check("mrst_mem_addr_async", 32'(mem_addr), 32'd0);
        step();
        check("mrst_no_done", {30'd0, done1, done0}, 32'd0);
        step();
        reset_n = 1'b1;

        // Tie from reset: 0,1,0,1 each three cycles apart.
        req0 = 1'b1; we0 = 1'b0; type0 = DM_WORD; addr0 = 32'h300;
        req1 = 1'b1; we1 = 1'b0; type1 = DM_WORD; addr1 = 32'h400;
        mem_ready = 1'b1; mem_rdata = 32'h5A5A0000;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("tie_gnt0_c%0d", c), 32'(gnt0), 32'((c % 6) == 0));
            check($sformatf("tie_gnt1_c%0d", c), 32'(gnt1), 32'((c % 6) == 3));
            check($sformatf("tie_mreq_c%0d", c), 32'(mem_req), 32'((c % 3) == 1));
            check($sformatf("tie_done0_c%0d", c), 32'(done0), 32'((c % 6) == 2));
            check($sformatf("tie_done1_c%0d", c), 32'(done1), 32'((c % 6) == 5));
            @(posedge clk);
            #1;
        end
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
